// File: rtl/uart_tx_frame.sv
// UART transmitter with built-in baud divider, configurable frame format and valid/ready input.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the transmitter.
module uart_tx_frame #(
   parameter int BAUD_DIV   = 625,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int CW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_frame: BAUD_DIV must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
      $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY == 1);
   endfunction

   state_t                 state, state_n;
   logic [BW-1:0]          baud_cnt, baud_n;
   logic [CW-1:0]          bit_cnt, bit_n;
   logic [DATA_BITS-1:0]   shreg, shreg_n;
   logic                   par_r, par_n;
   logic                   tx_n;
   logic                   bit_end, last_stop, can_load, load;
   logic                   src_valid;
   logic [DATA_BITS-1:0]   src_data;

`ifdef UART_TX_FIFO_EN
   localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [PW:0]          count;
   logic                 full, push;

   assign full      = (count == (PW+1)'(FIFO_DEPTH));
   assign push      = tx_valid && !full;
   assign src_valid = (count != '0);
   assign src_data  = mem[rd_ptr];
   assign tx_ready  = !full;
   assign busy      = (state != ST_IDLE) || src_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (load) rd_ptr <= rd_ptr + PW'(1);
         case ({push, load})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end
`else
   assign src_valid = tx_valid;
   assign src_data  = tx_data;
   assign tx_ready  = can_load;
   assign busy      = (state != ST_IDLE);
`endif

   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign last_stop = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
   assign can_load  = (state == ST_IDLE) || last_stop;
   assign load      = src_valid && can_load;
   assign tx_done   = last_stop;

   // Next state, counters and the registered line level for the following cycle
   always_comb begin
      state_n = state;
      baud_n  = bit_end ? '0 : baud_cnt + BAUD_ONE;
      bit_n   = bit_cnt;
      shreg_n = shreg;
      par_n   = par_r;
      tx_n    = tx;
      case (state)
         ST_IDLE: baud_n = '0;
         ST_START: begin
            if (bit_end) begin
               state_n = ST_DATA;
               bit_n   = '0;
               tx_n    = shreg[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_cnt == DATA_LAST) begin
                  bit_n = '0;
                  if (PARITY != 0) begin
                     state_n = ST_PARITY;
                     tx_n    = par_r;
                  end else begin
                     state_n = ST_STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_n   = bit_cnt + CNT_ONE;
                  shreg_n = shreg >> 1;
                  tx_n    = shreg[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_n = ST_STOP;
               bit_n   = '0;
               tx_n    = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_cnt == STOP_LAST) begin
                  state_n = ST_IDLE;
                  bit_n   = '0;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_cnt + CNT_ONE;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
         end
      endcase
      // A load in the final stop cycle chains straight into the next start bit
      if (load) begin
         state_n = ST_START;
         baud_n  = '0;
         bit_n   = '0;
         shreg_n = src_data;
         par_n   = parity_bit(src_data);
         tx_n    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         tx       <= tx_n;
      end
   end

   always_ff @(posedge clk) begin
      shreg <= shreg_n;
      par_r <= par_n;
   end

endmodule
